ysyx_22040228_div_unit: RTL and testbench

- Parametrised, iterative radix-2 restoring divider for the EXU. Handles RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW.
- Generalises the fixed 64-bit divider:
  - XLEN-wide datapath.
  - Decoded mode inputs instead of opcode compare.
  - Full RISC-V divide-by-zero and overflow semantics.
  - Shortened iteration count for word ops.
  - Valid/ready handshakes on both sides.
  - Flush for pipeline squash.
- Sits beside the multiplier in EXU. The result returns to EXU/WB via out_valid/out_ready.

---
 rtl/ysyx_22040228_div_unit.sv | 111 +++++++++++
 tb/tb_ysyx_22040228_div_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040228_div_unit.sv
// ysyx_22040228_div_unit: iterative radix-2 restoring divider for RV64M/RV32M div/rem ops
module ysyx_22040228_div_unit #(
    parameter int XLEN     = 64,
    parameter int WORD_OPS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            is_signed,
    input  logic            is_rem,
    input  logic            is_word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem, quo, dvs;
    logic            neg_q, neg_r, rem_op, word_op;
    logic            word, neg_a, neg_b, zero_div, ovf, ge;
    logic [XLEN-1:0] a, b, abs_a, abs_b, fin_q, fin_r, raw;
    logic [XLEN:0]   rem_sh;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] x);
        return XLEN'($signed(x));
    endfunction

    assign in_ready = (state == IDLE) && !flush;

    // Operand preparation, special-case detection and one restoring step
    always_comb begin
        word     = (WORD_OPS != 0) && is_word;
        a        = word ? (is_signed ? sext(dividend[31:0]) : XLEN'(dividend[31:0])) : dividend;
        b        = word ? (is_signed ? sext(divisor[31:0]) : XLEN'(divisor[31:0])) : divisor;
        neg_a    = is_signed && a[XLEN-1];
        neg_b    = is_signed && b[XLEN-1];
        abs_a    = neg_a ? -a : a;
        abs_b    = neg_b ? -b : b;
        zero_div = b == '0;
        ovf      = is_signed && (&b) && (a == (word ? sext(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}}));
        rem_sh   = {rem, quo[XLEN-1]};
        ge       = rem_sh >= {1'b0, dvs};
        fin_q    = neg_q ? -quo : quo;
        fin_r    = neg_r ? -rem : rem;
        raw      = rem_op ? fin_r : fin_q;
    end

    // Control FSM and datapath registers; special cases skip the iterations
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            rem_op    <= 1'b0;
            word_op   <= 1'b0;
            result    <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state   <= CALC;
                    rem_op  <= is_rem;
                    word_op <= word;
                    dvs     <= abs_b;
                    if (zero_div || ovf) begin
                        cnt   <= '0;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        quo   <= zero_div ? '1 : a;
                        rem   <= zero_div ? a : '0;
                    end else begin
                        cnt   <= word ? CW'(32) : CW'(XLEN);
                        neg_q <= neg_a ^ neg_b;
                        neg_r <= neg_a;
                        quo   <= word ? abs_a << (XLEN - 32) : abs_a;
                        rem   <= '0;
                    end
                end
                CALC: if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                    rem <= ge ? rem_sh[XLEN-1:0] - dvs : rem_sh[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], ge};
                end else begin
                    result    <= word_op ? sext(raw[31:0]) : raw;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22040228_div_unit.sv
// tb_ysyx_22040228_div_unit: vector, corner-case and random checks of the divider against a reference model
module tb_ysyx_22040228_div_unit;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, s, r, w, sel;
    logic [63:0] dividend, divisor;
    logic        ir64, ov64, ir32, ov32, ir, ov;
    logic [63:0] res64, res;
    logic [31:0] res32;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    ysyx_22040228_div_unit d64 (
        .clk(clk), .rst(rst), .flush(flush & !sel), .in_valid(in_valid & !sel), .in_ready(ir64),
        .dividend(dividend), .divisor(divisor), .is_signed(s), .is_rem(r), .is_word(w),
        .out_valid(ov64), .out_ready(out_ready & !sel), .result(res64)
    );

    ysyx_22040228_div_unit #(.XLEN(32), .WORD_OPS(0)) d32 (
        .clk(clk), .rst(rst), .flush(flush & sel), .in_valid(in_valid & sel), .in_ready(ir32),
        .dividend(dividend[31:0]), .divisor(divisor[31:0]), .is_signed(s), .is_rem(r), .is_word(w),
        .out_valid(ov32), .out_ready(out_ready & sel), .result(res32)
    );

    assign ir  = sel ? ir32 : ir64;
    assign ov  = sel ? ov32 : ov64;
    assign res = sel ? {32'b0, res32} : res64;

    typedef struct {
        logic [63:0] a, b;
        bit          sg, rm, wd;
        logic [63:0] exp;
        int          lat;
        string       nm;
    } vec_t;

    vec_t v[15];

    // RISC-V division semantics computed with plain SV arithmetic
    function automatic logic [63:0] model(input logic [63:0] a, b, input bit sg, rm, wd);
        logic [31:0] a32, b32, q32, m32, r32;
        logic [63:0] q, m;
        a32 = a[31:0];
        b32 = b[31:0];
        if (wd) begin
            if (b32 == 0) begin q32 = '1; m32 = a32; end
            else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; m32 = 0; end
            else if (sg) begin q32 = $signed(a32) / $signed(b32); m32 = $signed(a32) % $signed(b32); end
            else begin q32 = a32 / b32; m32 = a32 % b32; end
            r32 = rm ? m32 : q32;
            return {{32{r32[31]}}, r32};
        end
        if (b == 0) begin q = '1; m = a; end
        else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; m = 0; end
        else if (sg) begin q = $signed(a) / $signed(b); m = $signed(a) % $signed(b); end
        else begin q = a / b; m = a % b; end
        return rm ? m : q;
    endfunction

    function automatic int exp_lat(input logic [63:0] a, b, input bit sg, wd, input int xlen);
        bit sp;
        if (wd || xlen == 32) begin
            sp = b[31:0] == 0 || (sg && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
            return sp ? 1 : 33;
        end
        sp = b == 0 || (sg && a == 64'h8000_0000_0000_0000 && b == '1);
        return sp ? 1 : 65;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    task automatic start(input logic [63:0] a, b, input bit sg, rm, wd);
        @(negedge clk);
        chk("in_ready before accept", 64'(ir), 64'd1);
        dividend = a; divisor = b; s = sg; r = rm; w = wd; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
        s = 1'($urandom); r = 1'($urandom); w = 1'($urandom);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!ov && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid after take", 64'(ov), 64'd0);
        chk("in_ready after take", 64'(ir), 64'd1);
    endtask

    task automatic op(input logic [63:0] a, b, input bit sg, rm, wd, input logic [63:0] exp, input int lat, input string nm);
        int n;
        start(a, b, sg, rm, wd);
        wait_valid(n);
        chk({nm, " out_valid"}, 64'(ov), 64'd1);
        if (lat >= 0) chk({nm, " latency"}, 64'(n), 64'(lat));
        chk({nm, " result"}, res, exp);
        drain();
    endtask

    initial begin
        int          n;
        bit          seen;
        logic [63:0] a, b, m;
        bit          sg, rm, wd;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
        s = 1'b0; r = 1'b0; w = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset out_valid64", 64'(ov64), 64'd0);
        chk("reset result64", res64, 64'd0);
        chk("reset in_ready64", 64'(ir64), 64'd1);
        chk("reset out_valid32", 64'(ov32), 64'd0);
        chk("reset result32", 64'(res32), 64'd0);

        v[0]  = '{64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 65, "divu 100/7"};
        v[1]  = '{64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 64'd2, 65, "remu 100/7"};
        v[2]  = '{64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, 65, "div -20/3"};
        v[3]  = '{64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 65, "rem -20/3"};
        v[4]  = '{64'h1234, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divu x/0"};
        v[5]  = '{64'h1234, 64'd0, 1'b1, 1'b1, 1'b0, 64'h1234, 1, "rem x/0"};
        v[6]  = '{64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1, "div overflow"};
        v[7]  = '{64'h8000_0000_0000_0000, '1, 1'b1, 1'b1, 1'b0, 64'd0, 1, "rem overflow"};
        v[8]  = '{64'h0000_0001_8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, -1, "divw overflow"};
        v[9]  = '{64'hFFFF_FFFE, 64'd1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 33, "divuw"};
        v[10] = '{64'd7, 64'd0, 1'b0, 1'b1, 1'b1, 64'd7, 1, "remuw 7/0"};
        v[11] = '{'1, 64'h8000_0000_0000_0001, 1'b0, 1'b0, 1'b0, 64'd1, 65, "divu big divisor"};
        v[12] = '{'1, 64'h8000_0000_0000_0001, 1'b0, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFE, 65, "remu big divisor"};
        v[13] = '{64'hFFFF_FFFF_0000_0007, 64'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 33, "divw 7/-2"};
        v[14] = '{64'hFFFF_FFFF_0000_0007, 64'hFFFF_FFFE, 1'b1, 1'b1, 1'b1, 64'd1, 33, "remw 7/-2"};
        for (int i = 0; i < 15; i++) op(v[i].a, v[i].b, v[i].sg, v[i].rm, v[i].wd, v[i].exp, v[i].lat, v[i].nm);

        start(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
        wait_valid(n);
        chk("bp out_valid", 64'(ov), 64'd1);
        in_valid = 1'b1;
        dividend = 64'd50; divisor = 64'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp hold out_valid", 64'(ov), 64'd1);
            chk("bp hold result", res, 64'd14);
            chk("bp hold in_ready", 64'(ir), 64'd0);
        end
        in_valid = 1'b0;
        drain();

        start(64'd1000, 64'd7, 1'b0, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush in_ready", 64'(ir), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            seen |= ov;
        end
        chk("flush no out_valid", 64'(seen), 64'd0);
        flush = 1'b1;
        #1;
        chk("flush blocks in_ready", 64'(ir), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        op(64'd9, 64'd3, 1'b0, 1'b0, 1'b0, 64'd3, 65, "div after flush");

        start(64'd1000, 64'd3, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid reset out_valid", 64'(ov), 64'd0);
        chk("mid reset result", res, 64'd0);
        chk("mid reset in_ready", 64'(ir), 64'd1);

        for (int i = 0; i < 40; i++) begin
            sg = 1'($urandom); rm = 1'($urandom); wd = 1'($urandom);
            a  = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = '1;
                2:       b = 64'($urandom_range(1, 20));
                3:       b = {$urandom, $urandom} >> $urandom_range(0, 63);
                default: b = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 7) == 0) a = wd ? {32'($urandom), 32'h8000_0000} : 64'h8000_0000_0000_0000;
            op(a, b, sg, rm, wd, model(a, b, sg, rm, wd), exp_lat(a, b, sg, wd, 64), "rand64");
        end

        sel = 1'b1;
        op(64'hFFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFD, 33, "xlen32 div -7/2");
        for (int i = 0; i < 20; i++) begin
            sg = 1'($urandom); rm = 1'($urandom);
            a  = {32'b0, 32'($urandom)};
            b  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {32'b0, 32'($urandom) >> $urandom_range(0, 31)};
            if ($urandom_range(0, 5) == 0) begin a = 64'h8000_0000; b = 64'hFFFF_FFFF; end
            m = model(a, b, sg, rm, 1'b1);
            op(a, b, sg, rm, 1'b0, {32'b0, m[31:0]}, exp_lat(a, b, sg, 1'b0, 32), "rand32");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
